// File: rtl/univ_shift_reg.sv
// Universal shift register: shift left/right, rotate, parallel load and hold,
// with a serial-out bit and a strobe once WIDTH serial shifts form a word.
module univ_shift_reg #(
    parameter int unsigned     WIDTH     = 6,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      en,
    input  logic [2:0]                                mode,
    input  logic                                      din,
    input  logic [WIDTH-1:0]                          pdata,
    output logic [WIDTH-1:0]                          q,
    output logic                                      sout,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] bit_cnt,
    output logic                                      word_valid
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_word_valid;

    logic w_serial_shift;
    logic w_word_done;

    // Shifts in either direction advance the same word counter.
    assign w_serial_shift = en && ((mode == MODE_SHL) || (mode == MODE_SHR));
    assign w_word_done    = w_serial_shift && (r_bit_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q          <= RESET_VAL;
            r_sout       <= 1'b0;
            r_bit_cnt    <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= w_word_done;
            if (w_serial_shift) begin
                r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + CNT_W'(1);
            end
            if (en) begin
                case (mode)
                    MODE_SHL: begin
                        r_q    <= {r_q[WIDTH-2:0], din};
                        r_sout <= r_q[WIDTH-1];
                    end
                    MODE_SHR: begin
                        r_q    <= {din, r_q[WIDTH-1:1]};
                        r_sout <= r_q[0];
                    end
                    MODE_LOAD: begin
                        r_q       <= pdata;
                        r_bit_cnt <= '0;
                    end
                    MODE_ROL: begin
                        r_q    <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                        r_sout <= r_q[WIDTH-1];
                    end
                    MODE_ROR: begin
                        r_q    <= {r_q[0], r_q[WIDTH-1:1]};
                        r_sout <= r_q[0];
                    end
                    MODE_HOLD: begin
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign q          = r_q;
    assign sout       = r_sout;
    assign bit_cnt    = r_bit_cnt;
    assign word_valid = r_word_valid;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=6 with hand-computed expectations.
module tb_univ_shift_reg;

    localparam int unsigned WIDTH = 6;

    logic             clk;
    logic             rst;
    logic             en;
    logic [2:0]       mode;
    logic             din;
    logic [WIDTH-1:0] pdata;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic [2:0]       bit_cnt;
    logic             word_valid;

    int n_assert;
    int n_fail;

    univ_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(6'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .din        (din),
        .pdata      (pdata),
        .q          (q),
        .sout       (sout),
        .bit_cnt    (bit_cnt),
        .word_valid (word_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [5:0] eq, input logic es,
                           input logic [2:0] ec, input logic ew);
        chk({tag, ".q"},    32'(q),          32'(eq));
        chk({tag, ".sout"}, 32'(sout),       32'(es));
        chk({tag, ".cnt"},  32'(bit_cnt),    32'(ec));
        chk({tag, ".wv"},   32'(word_valid), 32'(ew));
    endtask

    // Apply inputs, take one rising edge, then settle before sampling.
    task automatic step(input logic s_rst, input logic s_en, input logic [2:0] s_mode,
                        input logic s_din, input logic [5:0] s_pdata);
        rst   = s_rst;
        en    = s_en;
        mode  = s_mode;
        din   = s_din;
        pdata = s_pdata;
        @(posedge clk);
        #1;
    endtask

    logic [5:0] shl_q [6];
    logic       shl_d [6];
    logic [5:0] shr_q [6];
    logic       shr_d [6];

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1; en = 1'b0; mode = 3'b000; din = 1'b0; pdata = '0;
        shl_d = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        shl_q = '{6'h01, 6'h02, 6'h05, 6'h0B, 6'h16, 6'h2C};
        shr_d = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        shr_q = '{6'h20, 6'h30, 6'h18, 6'h0C, 6'h06, 6'h03};

        // Reset beats a simultaneous load
        step(1'b1, 1'b1, 3'b011, 1'b0, 6'h3F);
        chk_all("reset", 6'h00, 1'b0, 3'd0, 1'b0);

        // Shift left one word
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 3'b001, shl_d[i], 6'h00);
            chk_all($sformatf("shl%0d", i), shl_q[i], 1'b0, 3'((i + 1) % 6), i == 5);
        end

        // Shift right one word from zero, then a 7th shift
        step(1'b1, 1'b0, 3'b000, 1'b0, 6'h00);
        chk_all("rst2", 6'h00, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 3'b010, shr_d[i], 6'h00);
            chk_all($sformatf("shr%0d", i), shr_q[i], 1'b0, 3'((i + 1) % 6), i == 5);
        end
        step(1'b0, 1'b1, 3'b010, 1'b0, 6'h00);
        chk_all("shr7", 6'h01, 1'b1, 3'd1, 1'b0);

        // Load then rotate; sout holds across load
        step(1'b0, 1'b1, 3'b011, 1'b0, 6'h21);
        chk_all("load1", 6'h21, 1'b1, 3'd0, 1'b0);
        step(1'b0, 1'b1, 3'b100, 1'b0, 6'h00);
        chk_all("rol", 6'h03, 1'b1, 3'd0, 1'b0);
        step(1'b0, 1'b1, 3'b011, 1'b0, 6'h21);
        chk_all("load2", 6'h21, 1'b1, 3'd0, 1'b0);
        step(1'b0, 1'b1, 3'b101, 1'b0, 6'h00);
        chk_all("ror", 6'h30, 1'b1, 3'd0, 1'b0);

        // Pause with en low and reserved mode mid-word
        step(1'b1, 1'b0, 3'b000, 1'b0, 6'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'b001, 1'b1, 6'h00);
        chk_all("pre_pause", 6'h07, 1'b0, 3'd3, 1'b0);
        step(1'b0, 1'b0, 3'b001, 1'b0, 6'h00);
        chk_all("pause1", 6'h07, 1'b0, 3'd3, 1'b0);
        step(1'b0, 1'b0, 3'b011, 1'b0, 6'h15);
        chk_all("pause2", 6'h07, 1'b0, 3'd3, 1'b0);
        step(1'b0, 1'b1, 3'b110, 1'b1, 6'h15);
        chk_all("rsvd110", 6'h07, 1'b0, 3'd3, 1'b0);
        step(1'b0, 1'b1, 3'b001, 1'b0, 6'h00);
        chk_all("resume1", 6'h0E, 1'b0, 3'd4, 1'b0);
        step(1'b0, 1'b1, 3'b001, 1'b0, 6'h00);
        chk_all("resume2", 6'h1C, 1'b0, 3'd5, 1'b0);
        step(1'b0, 1'b1, 3'b001, 1'b0, 6'h00);
        chk_all("resume3", 6'h38, 1'b0, 3'd0, 1'b1);
        step(1'b0, 1'b1, 3'b111, 1'b1, 6'h00);
        chk_all("rsvd111", 6'h38, 1'b0, 3'd0, 1'b0);

        // Abort mid-word with reset
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'b001, 1'b1, 6'h00);
        chk_all("pre_abort", 6'h0F, 1'b0, 3'd4, 1'b0);
        step(1'b1, 1'b1, 3'b001, 1'b1, 6'h00);
        chk_all("abort_rst", 6'h00, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 3'b001, 1'b1, 6'h00);
            chk($sformatf("post_rst%0d.wv", i), 32'(word_valid), 32'(i == 5));
        end
        chk("post_rst.q", 32'(q), 32'h3F);

        // Abort mid-word with load
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'b001, 1'b0, 6'h00);
        chk_all("pre_abort2", 6'h30, 1'b1, 3'd4, 1'b0);
        step(1'b0, 1'b1, 3'b011, 1'b0, 6'h2A);
        chk_all("abort_load", 6'h2A, 1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 3'b001, 1'b0, 6'h00);
            chk($sformatf("post_load%0d.wv", i), 32'(word_valid), 32'(i == 5));
            chk($sformatf("post_load%0d.cnt", i), 32'(bit_cnt), 32'((i + 1) % 6));
        end
        chk("post_load.q", 32'(q), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
